mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between instruction fetch (IF) and load/store (LS) in the npc core.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS has priority with a streak limit; each response is timeout-guarded.
module mem_port_arbiter #(
    parameter  int unsigned ADDR_W        = 64,
    parameter  int unsigned DATA_W        = 64,
    parameter  int unsigned MAX_LS_STREAK = 4,
    parameter  int unsigned TIMEOUT       = 255,
    localparam int unsigned MASK_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [MASK_W-1:0] ls_wmask_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              err_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned         STREAK_W   = 4;
    localparam int unsigned         TCNT_W     = 16;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner_ls;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [STREAK_W-1:0] r_streak;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_if_rvalid;
    logic                r_ls_rvalid;
    logic                r_err;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;

    logic                w_idle;
    logic                w_pick_if;
    logic                w_if_gnt;
    logic                w_ls_gnt;
    logic                w_any_gnt;
    logic                w_mem_hs;
    logic                w_resp_ok;
    logic                w_resp_to;
    logic                w_resp_done;

    // IF only overrides LS once LS has used up its streak while IF was waiting.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_pick_if   = if_req_i && (!ls_req_i || (r_streak == STREAK_MAX));
    assign w_if_gnt    = w_idle && w_pick_if;
    assign w_ls_gnt    = w_idle && ls_req_i && !w_pick_if;
    assign w_any_gnt   = w_if_gnt || w_ls_gnt;
    assign w_mem_hs    = (r_state == ST_REQ) && mem_ready_i;
    assign w_resp_ok   = (r_state == ST_RESP) && mem_rvalid_i;
    assign w_resp_to   = (r_state == ST_RESP) && !mem_rvalid_i && (r_tcnt == TCNT_LAST);
    assign w_resp_done = w_resp_ok || w_resp_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_gnt)   w_state_nxt = ST_REQ;
            ST_REQ:  if (mem_ready_i) w_state_nxt = ST_RESP;
            ST_RESP: if (w_resp_done) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        mem_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if_gnt_o = w_if_gnt;
                ls_gnt_o = w_ls_gnt;
            end
            ST_REQ:  mem_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured at grant and hold the mem_* bus steady until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else if (w_any_gnt) begin
            r_owner_ls <= w_ls_gnt;
            r_we       <= w_ls_gnt && ls_we_i;
            r_addr     <= w_ls_gnt ? ls_addr_i  : if_addr_i;
            r_wdata    <= w_ls_gnt ? ls_wdata_i : '0;
            r_wmask    <= w_ls_gnt ? ls_wmask_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (w_idle) begin
            if (w_if_gnt || !if_req_i) begin
                r_streak <= '0;
            end else if (w_ls_gnt && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
        end else if (w_mem_hs || w_resp_done) begin
            r_tcnt <= '0;
        end else if (r_state == ST_RESP) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    // Responses are registered, so the owner sees its rvalid one cycle after the memory answers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_resp_done && !r_owner_ls;
            r_ls_rvalid <= w_resp_done && r_owner_ls;
            r_err       <= w_resp_to;
            if (w_resp_done && !r_owner_ls) begin
                r_if_rdata <= w_resp_ok ? mem_rdata_i : '0;
            end
            if (w_resp_done && r_owner_ls) begin
                r_ls_rdata <= (w_resp_ok && !r_we) ? mem_rdata_i : '0;
            end
        end
    end

    assign if_rvalid_o = r_if_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign ls_rvalid_o = r_ls_rvalid;
    assign ls_rdata_o  = r_ls_rdata;
    assign err_o       = r_err;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wmask_o = r_wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a reactive memory model, a transaction-level
// reference model compared every cycle, and literal expectations for the documented scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned MW   = 8;
    localparam int          MAXS = 4;
    localparam int          TMO  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic [MW-1:0] ls_wmask_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          err_o;
    logic          mem_valid_o;
    logic          mem_ready_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [MW-1:0] mem_wmask_o;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    int            mem_ready_lat = 0;
    int            mem_resp_lat  = 1;
    bit            mem_respond   = 1'b1;
    bit            mem_stray     = 1'b0;
    logic [DW-1:0] mem_data      = '0;

    bit glog[$];
    bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .err_o(err_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_if_gnt"},    64'(if_gnt_o),    0);
        chk({tag, "_ls_gnt"},    64'(ls_gnt_o),    0);
        chk({tag, "_if_rvalid"}, 64'(if_rvalid_o), 0);
        chk({tag, "_ls_rvalid"}, 64'(ls_rvalid_o), 0);
        chk({tag, "_if_rdata"},  if_rdata_o,       0);
        chk({tag, "_ls_rdata"},  ls_rdata_o,       0);
        chk({tag, "_err"},       64'(err_o),       0);
        chk({tag, "_mem_valid"}, 64'(mem_valid_o), 0);
        chk({tag, "_mem_we"},    64'(mem_we_o),    0);
        chk({tag, "_mem_addr"},  mem_addr_o,       0);
        chk({tag, "_mem_wdata"}, mem_wdata_o,      0);
        chk({tag, "_mem_wmask"}, 64'(mem_wmask_o), 0);
    endtask

    // Memory side: accepts after mem_ready_lat stalled cycles, answers mem_resp_lat cycles later.
    initial begin : mem_bfm
        int  vcnt;
        int  rcnt;
        bit  pend;
        vcnt = 0;
        rcnt = 0;
        pend = 1'b0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            tick();
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!rst) begin
                vcnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    rcnt++;
                    if (rcnt == mem_resp_lat) begin
                        pend = 1'b0;
                        if (mem_respond) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i  = mem_data;
                        end
                    end
                end
                if (mem_stray) begin
                    mem_stray    = 1'b0;
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 64'hBAD0_BAD0;
                end
                if (mem_valid_o) begin
                    if (vcnt == mem_ready_lat) begin
                        mem_ready_i = 1'b1;
                        vcnt = 0;
                        pend = 1'b1;
                        rcnt = 0;
                    end else begin
                        vcnt++;
                    end
                end
            end
        end
    end

    // Reference model: one outstanding transaction, tracked as busy/accepted/wait-count.
    initial begin : ref_model
        bit            m_busy, m_acc, m_owner_ls, m_wdata_known;
        int            m_streak, m_waited;
        logic          e_if_rv, e_ls_rv, e_err, e_we;
        logic [DW-1:0] e_if_rd, e_ls_rd, e_wdata;
        logic [AW-1:0] e_addr;
        logic [MW-1:0] e_wmask;
        logic          x_want_if, x_if_gnt, x_ls_gnt;
        bit            x_fin, x_to;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 1'b0; m_acc = 1'b0; m_owner_ls = 1'b0; m_wdata_known = 1'b1;
                m_streak = 0; m_waited = 0;
                e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0; e_we = 1'b0;
                e_if_rd = '0; e_ls_rd = '0; e_wdata = '0; e_addr = '0; e_wmask = '0;
            end
            x_want_if = if_req_i && (!ls_req_i || (m_streak == MAXS));
            x_if_gnt  = rst && !m_busy && x_want_if;
            x_ls_gnt  = rst && !m_busy && ls_req_i && !x_want_if;
            chk("m_if_gnt",    64'(if_gnt_o),    64'(x_if_gnt));
            chk("m_ls_gnt",    64'(ls_gnt_o),    64'(x_ls_gnt));
            chk("m_mem_valid", 64'(mem_valid_o), 64'(m_busy && !m_acc));
            chk("m_mem_we",    64'(mem_we_o),    64'(e_we));
            chk("m_mem_addr",  mem_addr_o,       e_addr);
            chk("m_mem_wmask", 64'(mem_wmask_o), 64'(e_wmask));
            if (m_wdata_known) chk("m_mem_wdata", mem_wdata_o, e_wdata);
            chk("m_if_rvalid", 64'(if_rvalid_o), 64'(e_if_rv));
            chk("m_ls_rvalid", 64'(ls_rvalid_o), 64'(e_ls_rv));
            chk("m_err",       64'(err_o),       64'(e_err));
            chk("m_if_rdata",  if_rdata_o,       e_if_rd);
            chk("m_ls_rdata",  ls_rdata_o,       e_ls_rd);
            if (if_gnt_o) glog.push_back(1'b0);
            if (ls_gnt_o) glog.push_back(1'b1);
            if (rst) begin
                e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0;
                x_fin = 1'b0; x_to = 1'b0;
                if (!m_busy) begin
                    if (x_if_gnt || x_ls_gnt) begin
                        m_busy = 1'b1; m_acc = 1'b0; m_owner_ls = x_ls_gnt;
                        e_we    = x_ls_gnt && ls_we_i;
                        e_addr  = x_ls_gnt ? ls_addr_i : if_addr_i;
                        e_wmask = x_ls_gnt ? ls_wmask_i : '0;
                        e_wdata = ls_wdata_i;
                        m_wdata_known = x_ls_gnt;
                    end
                    if (x_if_gnt || !if_req_i) m_streak = 0;
                    else if (x_ls_gnt && m_streak < MAXS) m_streak++;
                end else if (!m_acc) begin
                    if (mem_ready_i) begin
                        m_acc = 1'b1;
                        m_waited = 0;
                    end
                end else if (mem_rvalid_i) begin
                    x_fin = 1'b1;
                end else begin
                    m_waited++;
                    if (m_waited == TMO) begin
                        x_fin = 1'b1;
                        x_to  = 1'b1;
                    end
                end
                if (x_fin) begin
                    m_busy = 1'b0;
                    e_err  = x_to;
                    if (m_owner_ls) begin
                        e_ls_rv = 1'b1;
                        e_ls_rd = (x_to || e_we) ? '0 : mem_rdata_i;
                    end else begin
                        e_if_rv = 1'b1;
                        e_if_rd = x_to ? '0 : mem_rdata_i;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        zero_checks("rst");
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();

        // IF-only read, response two cycles after acceptance
        mem_ready_lat = 0; mem_resp_lat = 2; mem_data = 64'h13;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
        @(negedge clk);
        chk("t1_if_gnt", 64'(if_gnt_o), 1);
        chk("t1_ls_gnt", 64'(ls_gnt_o), 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) if_req_i = 1'b0;
            @(negedge clk);
            chk("t1_if_rvalid", 64'(if_rvalid_o), 64'(c == 4));
            if (c == 1) begin
                chk("t1_mem_valid", 64'(mem_valid_o), 1);
                chk("t1_mem_addr", mem_addr_o, 64'h8000_0000);
            end
            if (c == 4) begin
                chk("t1_if_rdata", if_rdata_o, 64'h13);
                chk("t1_err", 64'(err_o), 0);
            end
        end
        idle_gap(3);

        // IF and LS together: LS write first, IF granted as the LS ack pulses
        mem_resp_lat = 1; mem_data = 64'h55;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0004;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 64'h1000;
        ls_wdata_i = 64'hDEAD; ls_wmask_i = 8'hFF;
        @(negedge clk);
        chk("t2_ls_gnt", 64'(ls_gnt_o), 1);
        chk("t2_if_gnt", 64'(if_gnt_o), 0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) ls_req_i = 1'b0;
            if (c == 4) if_req_i = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                chk("t2_mem_valid", 64'(mem_valid_o), 1);
                chk("t2_mem_we", 64'(mem_we_o), 1);
                chk("t2_mem_wmask", 64'(mem_wmask_o), 64'hFF);
                chk("t2_mem_wdata", mem_wdata_o, 64'hDEAD);
                chk("t2_mem_addr", mem_addr_o, 64'h1000);
            end
            if (c == 3) begin
                chk("t2_ls_rvalid", 64'(ls_rvalid_o), 1);
                chk("t2_ls_rdata", ls_rdata_o, 0);
                chk("t2_err", 64'(err_o), 0);
                chk("t2_if_gnt_late", 64'(if_gnt_o), 1);
            end
            if (c == 6) begin
                chk("t2_if_rvalid", 64'(if_rvalid_o), 1);
                chk("t2_if_rdata", if_rdata_o, 64'h55);
            end
        end
        idle_gap(3);

        // Both requesting continuously: streak limit forces every fifth grant to IF
        glog.delete();
        if_req_i = 1'b1; if_addr_i = 64'h8000_0008;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 64'h1100;
        n = 0;
        while (glog.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        chk("t3_grant_count", 64'(glog.size()), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < glog.size()) chk("t3_grant_order", 64'(glog[i]), 64'(exp_order[i]));
        end
        idle_gap(5);

        // Memory stalls ready for 10 cycles: request must stay stable
        mem_ready_lat = 10;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 64'h2000;
        ls_wdata_i = 64'h0123_4567_89AB_CDEF; ls_wmask_i = 8'h0F;
        @(negedge clk);
        chk("t4_ls_gnt", 64'(ls_gnt_o), 1);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin
                ls_req_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wmask_i = '0;
            end
            @(negedge clk);
            if (c <= 11) begin
                chk("t4_mem_valid", 64'(mem_valid_o), 1);
                chk("t4_mem_addr", mem_addr_o, 64'h2000);
                chk("t4_mem_wdata", mem_wdata_o, 64'h0123_4567_89AB_CDEF);
                chk("t4_mem_wmask", 64'(mem_wmask_o), 64'h0F);
            end
            if (c == 13) begin
                chk("t4_ls_rvalid", 64'(ls_rvalid_o), 1);
                chk("t4_ls_rdata", ls_rdata_o, 0);
            end
        end
        mem_ready_lat = 0;
        idle_gap(3);

        // LS read returns data
        mem_data = 64'hCAFE;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 64'h3000;
        @(negedge clk);
        chk("t5_rd_gnt", 64'(ls_gnt_o), 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) ls_req_i = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                chk("t5_rd_rvalid", 64'(ls_rvalid_o), 1);
                chk("t5_rd_rdata", ls_rdata_o, 64'hCAFE);
            end
        end
        idle_gap(2);

        // Memory never answers: timeout response after 8 RESP cycles, then a stray rvalid
        mem_respond = 1'b0;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 64'h3008;
        @(negedge clk);
        chk("t5_to_gnt", 64'(ls_gnt_o), 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) ls_req_i = 1'b0;
            @(negedge clk);
            chk("t5_to_rvalid", 64'(ls_rvalid_o), 64'(c == 10));
            if (c == 10) begin
                chk("t5_to_err", 64'(err_o), 1);
                chk("t5_to_rdata", ls_rdata_o, 0);
                chk("t5_to_if_rvalid", 64'(if_rvalid_o), 0);
            end
        end
        mem_respond = 1'b1;
        mem_stray = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            chk("t5_stray_ls_rvalid", 64'(ls_rvalid_o), 0);
            chk("t5_stray_if_rvalid", 64'(if_rvalid_o), 0);
            chk("t5_stray_mem_valid", 64'(mem_valid_o), 0);
        end
        idle_gap(2);

        // Reset while waiting in RESP drops the transaction silently
        mem_resp_lat = 5; mem_data = 64'h99;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0100;
        @(negedge clk);
        chk("t6_gnt", 64'(if_gnt_o), 1);
        tick();
        if_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        zero_checks("t6_rst");
        tick();
        tick();
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t6_no_if_rvalid", 64'(if_rvalid_o), 0);
            chk("t6_no_ls_rvalid", 64'(ls_rvalid_o), 0);
            chk("t6_no_mem_valid", 64'(mem_valid_o), 0);
            tick();
        end

        // Fresh IF request after reset behaves normally
        mem_resp_lat = 1; mem_data = 64'h77;
        if_req_i = 1'b1; if_addr_i = 64'h8000_0200;
        @(negedge clk);
        chk("t6_fresh_gnt", 64'(if_gnt_o), 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) if_req_i = 1'b0;
            @(negedge clk);
            if (c == 1) chk("t6_fresh_addr", mem_addr_o, 64'h8000_0200);
            if (c == 3) begin
                chk("t6_fresh_rvalid", 64'(if_rvalid_o), 1);
                chk("t6_fresh_rdata", if_rdata_o, 64'h77);
                chk("t6_fresh_err", 64'(err_o), 0);
            end
        end
        idle_gap(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
